// File: rtl/wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ram_arbiter
//  Brief    : Two-master (inst/data) to one-slave Wishbone classic arbiter with
//             round-robin grant, cyc bus lock and a stalled-strobe watchdog.
//  Revision : 1.0
// ============================================================================
module wb_ram_arbiter #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    input  logic [3:0]  inst_sel,
    input  logic        inst_we,
    input  logic        inst_cyc,
    input  logic        inst_stb,
    output logic [31:0] inst_rdata,
    output logic        inst_ack,
    output logic        inst_err,

    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_sel,
    input  logic        data_we,
    input  logic        data_cyc,
    input  logic        data_stb,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    output logic        data_err,

    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_sel,
    output logic        ram_we,
    output logic        ram_cyc,
    output logic        ram_stb,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,

    output logic [1:0]  grant
);

    localparam logic [1:0]      c_IDLE     = 2'd0;
    localparam logic [1:0]      c_OWN_INST = 2'd1;
    localparam logic [1:0]      c_OWN_DATA = 2'd2;

    localparam logic            c_M_INST   = 1'b0;
    localparam logic            c_M_DATA   = 1'b1;

    localparam logic [TO_W-1:0] c_TIMEOUT  = TO_W'(TIMEOUT);
    localparam logic            c_WDOG_EN  = (TIMEOUT != 0);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_last_grant;
    logic            w_last_grant_nxt;
    logic [TO_W-1:0] r_wdog_cnt;
    logic [TO_W-1:0] w_wdog_cnt_nxt;
    logic            r_err_pending;
    logic            w_err_pending_nxt;

    logic            w_own_inst;
    logic            w_own_data;
    logic            w_owned;
    logic            w_state_change;

    logic [31:0]     w_o_addr;
    logic [31:0]     w_o_wdata;
    logic [3:0]      w_o_sel;
    logic            w_o_we;
    logic            w_o_cyc;
    logic            w_o_stb;

    logic            w_stall;
    logic            w_timeout;

    assign w_own_inst = (r_state == c_OWN_INST);
    assign w_own_data = (r_state == c_OWN_DATA);
    assign w_owned    = w_own_inst | w_own_data;

    // ------------------------------------------------------------------
    // Owner selection: slave side is driven to zero whenever nobody owns it
    // ------------------------------------------------------------------
    always_comb begin
        w_o_addr  = '0;
        w_o_wdata = '0;
        w_o_sel   = '0;
        w_o_we    = 1'b0;
        w_o_cyc   = 1'b0;
        w_o_stb   = 1'b0;
        if (w_own_inst) begin
            w_o_addr  = inst_addr;
            w_o_wdata = inst_wdata;
            w_o_sel   = inst_sel;
            w_o_we    = inst_we;
            w_o_cyc   = inst_cyc;
            w_o_stb   = inst_stb;
        end else if (w_own_data) begin
            w_o_addr  = data_addr;
            w_o_wdata = data_wdata;
            w_o_sel   = data_sel;
            w_o_we    = data_we;
            w_o_cyc   = data_cyc;
            w_o_stb   = data_stb;
        end
    end

    assign ram_addr  = w_o_addr;
    assign ram_wdata = w_o_wdata;
    assign ram_sel   = w_o_sel;
    assign ram_we    = w_o_we;
    assign ram_cyc   = w_o_cyc;
    assign ram_stb   = w_o_stb & ~r_err_pending;

    // An ack on the same cycle as the timeout wins because w_stall excludes it
    assign w_stall   = ram_cyc & ram_stb & ~ram_ack;
    assign w_timeout = c_WDOG_EN & w_stall & (r_wdog_cnt == c_TIMEOUT);

    assign inst_ack   = w_own_inst & ram_ack;
    assign data_ack   = w_own_data & ram_ack;
    assign inst_err   = w_own_inst & w_timeout;
    assign data_err   = w_own_data & w_timeout;
    assign inst_rdata = ram_rdata;
    assign data_rdata = ram_rdata;
    assign grant      = {w_own_data, w_own_inst};

    // ------------------------------------------------------------------
    // Arbitration FSM: ownership held while the owner keeps cyc asserted
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            c_IDLE: begin
                if (inst_cyc && data_cyc) begin
                    w_state_nxt = (r_last_grant == c_M_DATA) ? c_OWN_INST : c_OWN_DATA;
                end else if (inst_cyc) begin
                    w_state_nxt = c_OWN_INST;
                end else if (data_cyc) begin
                    w_state_nxt = c_OWN_DATA;
                end
            end
            c_OWN_INST: begin
                if (!inst_cyc) begin
                    w_last_grant_nxt = c_M_INST;
                    w_state_nxt      = data_cyc ? c_OWN_DATA : c_IDLE;
                end
            end
            c_OWN_DATA: begin
                if (!data_cyc) begin
                    w_last_grant_nxt = c_M_DATA;
                    w_state_nxt      = inst_cyc ? c_OWN_INST : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign w_state_change = (w_state_nxt != r_state);

    always_comb begin
        w_wdog_cnt_nxt = '0;
        if (c_WDOG_EN && !w_state_change && w_stall && !w_timeout) begin
            w_wdog_cnt_nxt = r_wdog_cnt + TO_W'(1);
        end
    end

    // Strobe stays masked after an error until the owner ends that access
    always_comb begin
        w_err_pending_nxt = r_err_pending;
        if (w_state_change || !w_owned) begin
            w_err_pending_nxt = 1'b0;
        end else if (w_timeout) begin
            w_err_pending_nxt = 1'b1;
        end else if (!w_o_stb || !w_o_cyc) begin
            w_err_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_last_grant  <= c_M_DATA;
            r_wdog_cnt    <= '0;
            r_err_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_wdog_cnt    <= w_wdog_cnt_nxt;
            r_err_pending <= w_err_pending_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_ram_arbiter
//  Brief    : Directed and randomized self-checking bench for wb_ram_arbiter.
//  Revision : 1.0
// ============================================================================
module tb_wb_ram_arbiter;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [3:0]  inst_sel;
    logic        inst_we, inst_cyc, inst_stb, inst_ack, inst_err;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_sel;
    logic        data_we, data_cyc, data_stb, data_ack, data_err;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;
    logic        ram_we, ram_cyc, ram_stb, ram_ack;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0 = none, 1 = inst, 2 = data
    int   m_owner;
    int   m_last;
    int   m_stall;
    bit   m_pend;
    bit   e_cyc, e_stb_in, e_stb, e_timeout;

    always #5 clk = ~clk;

    wb_ram_arbiter #(.TIMEOUT(TB_TIMEOUT), .TO_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_sel(inst_sel),
        .inst_we(inst_we), .inst_cyc(inst_cyc), .inst_stb(inst_stb),
        .inst_rdata(inst_rdata), .inst_ack(inst_ack), .inst_err(inst_err),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_sel(data_sel),
        .data_we(data_we), .data_cyc(data_cyc), .data_stb(data_stb),
        .data_rdata(data_rdata), .data_ack(data_ack), .data_err(data_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_sel(ram_sel),
        .ram_we(ram_we), .ram_cyc(ram_cyc), .ram_stb(ram_stb),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .grant(grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 2;
        m_stall = 0;
        m_pend  = 1'b0;
    endtask

    // Wait for the mid-cycle point and compare every output to the model
    task automatic sample();
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_sel;
        logic        e_we;
        logic [1:0]  e_grant;
        @(negedge clk);
        e_addr = '0; e_wdata = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb_in = 1'b0;
        if (m_owner == 1) begin
            e_addr = inst_addr; e_wdata = inst_wdata; e_sel = inst_sel;
            e_we = inst_we; e_cyc = inst_cyc; e_stb_in = inst_stb;
        end else if (m_owner == 2) begin
            e_addr = data_addr; e_wdata = data_wdata; e_sel = data_sel;
            e_we = data_we; e_cyc = data_cyc; e_stb_in = data_stb;
        end
        e_grant   = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        e_stb     = e_stb_in && !m_pend;
        e_timeout = e_cyc && e_stb && !ram_ack && (m_stall == TB_TIMEOUT);
        chk("m_grant",    grant,     e_grant);
        chk("m_ram_cyc",  ram_cyc,   e_cyc);
        chk("m_ram_stb",  ram_stb,   e_stb);
        chk("m_ram_addr", ram_addr,  e_addr);
        chk("m_ram_wdat", ram_wdata, e_wdata);
        chk("m_ram_sel",  ram_sel,   e_sel);
        chk("m_ram_we",   ram_we,    e_we);
        chk("m_inst_ack", inst_ack,  (m_owner == 1) && ram_ack);
        chk("m_data_ack", data_ack,  (m_owner == 2) && ram_ack);
        chk("m_inst_err", inst_err,  (m_owner == 1) && e_timeout);
        chk("m_data_err", data_err,  (m_owner == 2) && e_timeout);
        if (inst_ack === 1'b1) chk("m_inst_rdata", inst_rdata, ram_rdata);
        if (data_ack === 1'b1) chk("m_data_rdata", data_rdata, ram_rdata);
    endtask

    // Advance the model by the current inputs, then step the clock
    task automatic advance();
        bit other_cyc;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (inst_cyc && data_cyc) m_owner = (m_last == 2) ? 1 : 2;
            else if (inst_cyc)        m_owner = 1;
            else if (data_cyc)        m_owner = 2;
            m_stall = 0;
            m_pend  = 1'b0;
        end else if (!e_cyc) begin
            other_cyc = (m_owner == 1) ? data_cyc : inst_cyc;
            m_last  = m_owner;
            m_owner = other_cyc ? 3 - m_owner : 0;
            m_stall = 0;
            m_pend  = 1'b0;
        end else if (e_timeout) begin
            m_stall = 0;
            m_pend  = 1'b1;
        end else begin
            m_stall = (e_stb && !ram_ack) ? m_stall + 1 : 0;
            if (!e_stb_in) m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        inst_addr = '0; inst_wdata = '0; inst_sel = '0; inst_we = 1'b0;
        inst_cyc = 1'b0; inst_stb = 1'b0;
        data_addr = '0; data_wdata = '0; data_sel = '0; data_we = 1'b0;
        data_cyc = 1'b0; data_stb = 1'b0;
        ram_rdata = '0; ram_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        sample();
        chk("rst_grant",   grant,    2'b00);
        chk("rst_ram_cyc", ram_cyc,  1'b0);
        chk("rst_ram_stb", ram_stb,  1'b0);
        chk("rst_addr",    ram_addr, 32'h0);
        chk("rst_acks",    {inst_ack, data_ack, inst_err, data_err}, 4'h0);
        advance();
        rst_n = 1'b1;

        // Inst-only read, slave acks two cycles after stb
        inst_cyc = 1'b1; inst_stb = 1'b1; inst_addr = 32'h0000_0010; inst_sel = 4'hF;
        sample(); chk("t1_latency", grant, 2'b00); advance();
        sample(); chk("t1_grant", grant, 2'b01); chk("t1_addr", ram_addr, 32'h10); advance();
        idle_cycle();
        ram_ack = 1'b1; ram_rdata = 32'hDEAD_BEEF;
        sample();
        chk("t1_ack", inst_ack, 1'b1);
        chk("t1_rdata", inst_rdata, 32'hDEAD_BEEF);
        chk("t1_data_ack", data_ack, 1'b0);
        advance();
        ram_ack = 1'b0; inst_cyc = 1'b0; inst_stb = 1'b0;
        sample(); chk("t1_ack_once", inst_ack, 1'b0); advance();

        // Simultaneous requests out of reset, then round-robin
        do_reset();
        inst_cyc = 1'b1; inst_stb = 1'b1; inst_addr = 32'h100;
        data_cyc = 1'b1; data_stb = 1'b1; data_addr = 32'h200; data_sel = 4'hF;
        idle_cycle();
        ram_ack = 1'b1;
        sample(); chk("t2_first", grant, 2'b01); chk("t2_data_noack", data_ack, 1'b0); advance();
        ram_ack = 1'b0; inst_cyc = 1'b0; inst_stb = 1'b0;
        idle_cycle();
        ram_ack = 1'b1;
        sample(); chk("t2_handover", grant, 2'b10); chk("t2_data_ack", data_ack, 1'b1); advance();
        ram_ack = 1'b0; data_cyc = 1'b0; data_stb = 1'b0;
        idle_cycle();
        inst_cyc = 1'b1; inst_stb = 1'b1; data_cyc = 1'b1; data_stb = 1'b1;
        idle_cycle();
        sample(); chk("t2_rr_again", grant, 2'b01); advance();
        inst_cyc = 1'b0; inst_stb = 1'b0; data_cyc = 1'b0; data_stb = 1'b0;
        idle_cycle();

        // Data holds cyc over three beats while inst waits
        inst_cyc = 1'b1; inst_stb = 1'b1; inst_addr = 32'h180;
        data_cyc = 1'b1; data_stb = 1'b1;
        idle_cycle();
        for (int b = 0; b < 3; b++) begin
            data_we    = (b == 0);
            data_sel   = (b == 0) ? 4'b0011 : 4'b1111;
            data_addr  = 32'h300 + 32'(4 * b);
            data_wdata = 32'h1234_5678 + 32'(b);
            sample(); chk("t3_hold", grant, 2'b10); advance();
            ram_ack = 1'b1;
            sample();
            chk("t3_beat_ack", data_ack, 1'b1);
            chk("t3_inst_wait", inst_ack, 1'b0);
            chk("t3_sel", ram_sel, data_sel);
            advance();
            ram_ack = 1'b0;
        end
        data_cyc = 1'b0; data_stb = 1'b0;
        idle_cycle();
        ram_ack = 1'b1;
        sample(); chk("t3_inst_after", grant, 2'b01); chk("t3_inst_ack", inst_ack, 1'b1); advance();
        ram_ack = 1'b0; inst_cyc = 1'b0; inst_stb = 1'b0;
        idle_cycle();

        // Watchdog: slave never acks
        data_cyc = 1'b1; data_stb = 1'b1; data_we = 1'b0; data_addr = 32'h400;
        idle_cycle();
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            sample(); chk("t4_no_err_yet", data_err, 1'b0); advance();
        end
        sample(); chk("t4_err", data_err, 1'b1); advance();
        for (int k = 0; k < 2; k++) begin
            sample(); chk("t4_err_once", data_err, 1'b0); chk("t4_stb_masked", ram_stb, 1'b0); advance();
        end
        data_stb = 1'b0;
        idle_cycle();
        data_stb = 1'b1; ram_ack = 1'b1; ram_rdata = 32'hCAFE_F00D;
        sample();
        chk("t4_stb_back", ram_stb, 1'b1);
        chk("t4_ack", data_ack, 1'b1);
        chk("t4_rdata", data_rdata, 32'hCAFE_F00D);
        advance();
        ram_ack = 1'b0; data_cyc = 1'b0; data_stb = 1'b0;
        idle_cycle();

        // Reset in the middle of an inst read, late ack discarded
        inst_cyc = 1'b1; inst_stb = 1'b1; inst_addr = 32'h500;
        idle_cycle();
        sample(); chk("t5_owned", grant, 2'b01); advance();
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1; ram_ack = 1'b1;
        sample();
        chk("t5_grant", grant, 2'b00);
        chk("t5_cyc", ram_cyc, 1'b0);
        chk("t5_acks", {inst_ack, data_ack}, 2'b00);
        advance();
        ram_ack = 1'b0; inst_cyc = 1'b0; inst_stb = 1'b0;
        sample(); chk("t5_inst_ack", inst_ack, 1'b0); advance();

        // Ack landing exactly on the timeout cycle
        inst_cyc = 1'b1; inst_stb = 1'b1; inst_addr = 32'h600;
        idle_cycle();
        for (int k = 0; k < TB_TIMEOUT; k++) idle_cycle();
        ram_ack = 1'b1;
        sample(); chk("t6_ack_wins", inst_ack, 1'b1); chk("t6_no_err", inst_err, 1'b0); advance();
        ram_ack = 1'b0; inst_cyc = 1'b0; inst_stb = 1'b0;
        idle_cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) inst_cyc = ~inst_cyc;
            if ($urandom_range(0, 7) == 0) data_cyc = ~data_cyc;
            if ($urandom_range(0, 5) == 0) inst_stb = ~inst_stb;
            if ($urandom_range(0, 5) == 0) data_stb = ~data_stb;
            inst_addr  = $urandom; inst_wdata = $urandom;
            inst_sel   = 4'($urandom); inst_we = 1'($urandom);
            data_addr  = $urandom; data_wdata = $urandom;
            data_sel   = 4'($urandom); data_we = 1'($urandom);
            ram_rdata  = $urandom;
            ram_ack    = ($urandom_range(0, 4) == 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
